// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N up/down counter with enable, synchronous
// parallel load, registered wrap pulse and a zero flag.
// Optional feature: define MOD_COUNTER_PRESCALE_EN to insert a divider on CE so
// that only every PRESCALE-th enabled cycle advances the count.
module mod_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     PRESCALE = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             ZERO
);

    // The modulus and last legal value are held one bit wider than the count so
    // that MODULUS = 2**WIDTH is representable and compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   LAST_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LAST_VAL = LAST_EXT[WIDTH-1:0];

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 2) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             cout_q;
    logic             cout_d;
    logic             step;

    logic [WIDTH:0]   countExt;
    logic [WIDTH:0]   dataExt;
    logic [WIDTH:0]   incExt;
    logic             upWrap;
    logic             downWrap;
    logic [WIDTH-1:0] upNext;
    logic [WIDTH-1:0] downNext;
    logic [WIDTH-1:0] loadVal;

    assign countExt = {1'b0, count_q};
    assign dataExt  = {1'b0, DATA};
    assign incExt   = countExt + (WIDTH+1)'(1);

    // An up step wraps when the widened increment reaches the modulus.
    assign upWrap   = (incExt == MOD_EXT);
    assign downWrap = (count_q == '0);
    assign upNext   = upWrap ? '0 : incExt[WIDTH-1:0];
    assign downNext = downWrap ? LAST_VAL : (count_q - WIDTH'(1));

    // Out-of-range load values clamp to the last legal count.
    assign loadVal  = (dataExt < MOD_EXT) ? DATA : LAST_VAL;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int               DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Divider advances on each enabled cycle, returns to 0 after its last value,
    // freezes while CE is low and is cleared by a load.
    always_comb begin
        div_d = div_q;
        if (LOAD) begin
            div_d = '0;
        end else if (CE) begin
            div_d = (div_q == DIV_LAST) ? '0 : (div_q + DIV_W'(1));
        end
    end

    // Divider register, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign step = CE && (div_q == DIV_LAST);
`else
    assign step = CE;
`endif

    // Next count and wrap pulse: load beats a step, and the pulse is only
    // raised by a step that wraps.
    always_comb begin
        count_d = count_q;
        cout_d  = 1'b0;
        if (LOAD) begin
            count_d = loadVal;
        end else if (step) begin
            if (UP) begin
                count_d = upNext;
                cout_d  = upWrap;
            end else begin
                count_d = downNext;
                cout_d  = downWrap;
            end
        end
    end

    // Count and wrap-pulse registers with synchronous reset taking priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cout_q  <= cout_d;
        end
    end

    assign O    = count_q;
    assign COUT = cout_q;
    assign ZERO = (count_q == '0);

endmodule
